// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue
// Brief    : Instruction prefetch queue with a single-outstanding memory
//            request FSM, redirect flush and halt freeze.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h00000000
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     imem_req,
    output logic [31:0]              imem_addr,
    input  logic                     imem_ack,
    input  logic [31:0]              imem_rdata,
    input  logic                     redirect,
    input  logic [31:0]              redirect_pc,
    input  logic                     halt,
    output logic                     inst_valid,
    output logic [31:0]              inst,
    output logic [31:0]              inst_pc,
    input  logic                     inst_ready,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned    c_AW       = $clog2(DEPTH);
    localparam logic [31:0]    c_NOP      = 32'h00000013;
    localparam logic [c_AW:0]  c_DEPTH    = DEPTH[c_AW:0];
    localparam logic [c_AW:0]  c_CNT_ONE  = 1;
    localparam logic [c_AW-1:0] c_PTR_ONE = 1;

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_WAIT = 2'd1;
    localparam logic [1:0] c_S_KILL = 2'd2;

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic [31:0]     r_fetch_pc;
    logic [31:0]     w_fetch_pc_nxt;
    logic            r_imem_req;
    logic            w_req_nxt;
    logic [31:0]     r_imem_addr;
    logic [31:0]     w_addr_nxt;
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_AW:0]   r_count;
    logic [c_AW:0]   w_count_nxt;
    logic [31:0]     r_pc_mem   [DEPTH];
    logic [31:0]     r_inst_mem [DEPTH];

    logic            w_ack;
    logic            w_push;
    logic            w_pop;
    logic [31:0]     w_target;
    logic [31:0]     w_pc_inc;
    logic            w_unused;

    assign w_target = {redirect_pc[31:2], 2'b00};
    assign w_unused = ^redirect_pc[1:0];
    assign w_pc_inc = r_fetch_pc + 32'd4;
    assign w_ack    = r_imem_req & imem_ack;
    // A pop coinciding with a redirect is discarded along with the flush.
    assign w_pop    = inst_valid & inst_ready & ~redirect;
    assign w_push   = (r_state == c_S_WAIT) & w_ack & ~redirect;

    always_comb begin
        w_count_nxt = r_count;
        if (redirect) begin
            w_count_nxt = '0;
        end else if (w_push && !w_pop) begin
            w_count_nxt = r_count + c_CNT_ONE;
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - c_CNT_ONE;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_fetch_pc_nxt = r_fetch_pc;
        w_req_nxt      = r_imem_req;
        w_addr_nxt     = r_imem_addr;
        case (r_state)
            c_S_IDLE: begin
                if (redirect) begin
                    w_fetch_pc_nxt = w_target;
                end
                // A redirect empties the queue, so there is always room for it.
                if (!halt && (redirect || (r_count < c_DEPTH))) begin
                    w_req_nxt   = 1'b1;
                    w_addr_nxt  = redirect ? w_target : r_fetch_pc;
                    w_state_nxt = c_S_WAIT;
                end
            end
            c_S_WAIT: begin
                if (redirect) begin
                    w_fetch_pc_nxt = w_target;
                    if (w_ack) begin
                        w_req_nxt   = 1'b0;
                        w_state_nxt = c_S_IDLE;
                    end else begin
                        w_state_nxt = c_S_KILL;
                    end
                end else if (w_ack) begin
                    w_fetch_pc_nxt = w_pc_inc;
                    if (!halt && (w_count_nxt < c_DEPTH)) begin
                        w_addr_nxt = w_pc_inc;
                    end else begin
                        w_req_nxt   = 1'b0;
                        w_state_nxt = c_S_IDLE;
                    end
                end
            end
            c_S_KILL: begin
                if (redirect) begin
                    w_fetch_pc_nxt = w_target;
                end
                if (w_ack) begin
                    w_req_nxt   = 1'b0;
                    w_state_nxt = c_S_IDLE;
                end
            end
            default: begin
                w_req_nxt   = 1'b0;
                w_state_nxt = c_S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= c_S_IDLE;
            r_fetch_pc  <= RESET_PC;
            r_imem_req  <= 1'b0;
            r_imem_addr <= RESET_PC;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_fetch_pc  <= w_fetch_pc_nxt;
            r_imem_req  <= w_req_nxt;
            r_imem_addr <= w_addr_nxt;
            r_count     <= w_count_nxt;
            if (redirect) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
                end
            end
        end
    end

    // Payload storage carries no reset; validity is tracked by r_count alone.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pc_mem[r_wr_ptr]   <= r_fetch_pc;
            r_inst_mem[r_wr_ptr] <= imem_rdata;
        end
    end

    assign imem_req   = r_imem_req;
    assign imem_addr  = r_imem_addr;
    assign count      = r_count;
    assign inst_valid = (r_count != '0);
    assign inst       = inst_valid ? r_inst_mem[r_rd_ptr] : c_NOP;
    assign inst_pc    = inst_valid ? r_pc_mem[r_rd_ptr] : 32'h00000000;

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_queue
// Brief    : Self-checking bench for fetch_queue: queue-based reference model
//            compared every cycle, plus directed literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_queue;

    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] NOP   = 32'h00000013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ack_en = 1'b0;
    logic        ack_force = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        halt = 1'b0;
    logic        inst_ready = 1'b0;

    wire logic        imem_req;
    wire logic [31:0] imem_addr;
    wire logic        imem_ack;
    wire logic [31:0] imem_rdata;
    wire logic        inst_valid;
    wire logic [31:0] inst;
    wire logic [31:0] inst_pc;
    wire logic [2:0]  count;

    logic        rst_w = 1'b0;
    logic        ready_w = 1'b0;
    wire logic        req_w;
    wire logic [31:0] addr_w;
    wire logic [31:0] rdata_w;
    wire logic        valid_w;
    wire logic [31:0] inst_w;
    wire logic [31:0] pc_w;
    wire logic [2:0]  count_w;

    int n_checks = 0;
    int n_errors = 0;
    int n_acks = 0;
    logic count_acks = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[31:2], 2'b11} ^ 32'h5A000000;
    endfunction

    assign imem_ack   = ack_force | (ack_en & imem_req);
    assign imem_rdata = mem_word(imem_addr);
    assign rdata_w    = mem_word(addr_w);

    always #5 clk = ~clk;

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h00000000)) u_dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
        .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
        .inst_ready(inst_ready), .count(count)
    );

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'hFFFFFFF8)) u_dut_wrap (
        .clk(clk), .rst(rst_w),
        .imem_req(req_w), .imem_addr(addr_w),
        .imem_ack(req_w), .imem_rdata(rdata_w),
        .redirect(1'b0), .redirect_pc(32'h0), .halt(1'b0),
        .inst_valid(valid_w), .inst(inst_w), .inst_pc(pc_w),
        .inst_ready(ready_w), .count(count_w)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    ent_t        m_q[$];
    logic [31:0] m_fpc = 32'h0;
    logic [31:0] m_addr = 32'h0;
    logic        m_out = 1'b0;
    logic        m_kill = 1'b0;
    int          m_pre;
    logic        m_ack, m_pop, m_push;
    logic [31:0] m_tgt;

    always @(posedge clk) begin
        if (!rst) begin
            m_q.delete();
            m_fpc  = 32'h0;
            m_addr = 32'h0;
            m_out  = 1'b0;
            m_kill = 1'b0;
        end else begin
            m_pre  = m_q.size();
            m_ack  = m_out && (ack_en || ack_force);
            m_pop  = (m_pre > 0) && inst_ready && !redirect;
            m_push = m_ack && !m_kill && !redirect;
            m_tgt  = {redirect_pc[31:2], 2'b00};
            if (redirect) begin
                m_q.delete();
            end else begin
                if (m_pop) void'(m_q.pop_front());
                if (m_push) m_q.push_back({m_addr, mem_word(m_addr)});
            end
            if (m_out) begin
                if (redirect) begin
                    m_fpc = m_tgt;
                    if (m_ack) begin
                        m_out = 1'b0;
                        m_kill = 1'b0;
                    end else begin
                        m_kill = 1'b1;
                    end
                end else if (m_ack) begin
                    if (m_kill) begin
                        m_out = 1'b0;
                        m_kill = 1'b0;
                    end else begin
                        m_fpc = m_fpc + 32'd4;
                        if (!halt && m_q.size() < DEPTH) m_addr = m_fpc;
                        else m_out = 1'b0;
                    end
                end
            end else begin
                if (redirect) m_fpc = m_tgt;
                if (!halt && (redirect || m_pre < DEPTH)) begin
                    m_out = 1'b1;
                    m_addr = m_fpc;
                end
            end
        end
    end

    always @(posedge clk) begin
        if (count_acks && imem_req && imem_ack) n_acks++;
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (!rst) begin
            check("rst_valid", {31'b0, inst_valid}, 32'd0);
            check("rst_inst", inst, NOP);
            check("rst_pc", inst_pc, 32'h0);
            check("rst_count", {29'b0, count}, 32'd0);
            check("rst_req", {31'b0, imem_req}, 32'd0);
            check("rst_addr", imem_addr, 32'h0);
        end else begin
            check("valid", {31'b0, inst_valid}, {31'b0, m_q.size() != 0});
            check("inst", inst, (m_q.size() != 0) ? m_q[0].ins : NOP);
            check("inst_pc", inst_pc, (m_q.size() != 0) ? m_q[0].pc : 32'h0);
            check("count", {29'b0, count}, m_q.size());
            check("req", {31'b0, imem_req}, {31'b0, m_out});
            if (m_out) check("addr", imem_addr, m_addr);
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        cycles(2);
        check("lit_reset_req", {31'b0, imem_req}, 32'd0);
        check("lit_reset_inst", inst, 32'h00000013);

        // streaming: one instruction per cycle
        rst = 1'b1; ack_en = 1'b1; inst_ready = 1'b1;
        cycles(1);
        check("lit_first_req", {31'b0, imem_req}, 32'd1);
        check("lit_first_addr", imem_addr, 32'h0);
        cycles(1);
        check("lit_first_valid", {31'b0, inst_valid}, 32'd1);
        check("lit_first_pc", inst_pc, 32'h0);
        cycles(1);
        check("lit_second_pc", inst_pc, 32'h4);
        cycles(1);
        check("lit_third_pc", inst_pc, 32'h8);
        cycles(4);

        // drain, then fill with consumer stalled
        ack_en = 1'b0;
        cycles(3);
        inst_ready = 1'b0; ack_en = 1'b1; n_acks = 0; count_acks = 1'b1;
        cycles(8);
        count_acks = 1'b0;
        check("lit_fill_acks", n_acks, 32'd4);
        check("lit_fill_count", {29'b0, count}, 32'd4);
        check("lit_fill_req", {31'b0, imem_req}, 32'd0);
        inst_ready = 1'b1;
        cycles(1);
        check("lit_resume_idle", {31'b0, imem_req}, 32'd0);
        cycles(1);
        check("lit_resume_req", {31'b0, imem_req}, 32'd1);

        // three queued, idle, then redirect
        inst_ready = 1'b0;
        cycles(4);
        inst_ready = 1'b1;
        cycles(1);
        check("lit_three_count", {29'b0, count}, 32'd3);
        check("lit_three_req", {31'b0, imem_req}, 32'd0);
        inst_ready = 1'b0; ack_en = 1'b0; redirect = 1'b1; redirect_pc = 32'h00000103;
        cycles(1);
        redirect = 1'b0;
        check("lit_redir_count", {29'b0, count}, 32'd0);
        check("lit_redir_addr", imem_addr, 32'h00000100);

        // redirect while waiting -> response killed
        redirect = 1'b1; redirect_pc = 32'h00000200;
        cycles(1);
        redirect = 1'b0;
        check("lit_kill_addr", imem_addr, 32'h00000100);
        cycles(3);
        ack_force = 1'b1;
        cycles(1);
        ack_force = 1'b0;
        check("lit_kill_count", {29'b0, count}, 32'd0);
        cycles(1);
        check("lit_kill_next", imem_addr, 32'h00000200);

        // halt while waiting
        halt = 1'b1;
        cycles(2);
        ack_force = 1'b1;
        cycles(1);
        ack_force = 1'b0;
        check("lit_halt_count", {29'b0, count}, 32'd1);
        check("lit_halt_pc", inst_pc, 32'h00000200);
        check("lit_halt_req", {31'b0, imem_req}, 32'd0);
        inst_ready = 1'b1;
        cycles(2);
        check("lit_drain_count", {29'b0, count}, 32'd0);
        check("lit_drain_inst", inst, 32'h00000013);
        halt = 1'b0;
        cycles(1);
        check("lit_unhalt_addr", imem_addr, 32'h00000204);

        // redirect with ack in the same cycle
        inst_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h00000302; ack_force = 1'b1;
        cycles(1);
        redirect = 1'b0; ack_force = 1'b0;
        check("lit_redack_count", {29'b0, count}, 32'd0);
        cycles(1);
        check("lit_redack_addr", imem_addr, 32'h00000300);

        // asynchronous reset mid-request
        rst = 1'b0;
        #1;
        check("lit_async_req", {31'b0, imem_req}, 32'd0);
        cycles(1);
        ack_force = 1'b1; rst = 1'b1;
        cycles(1);
        check("lit_postrst_count", {29'b0, count}, 32'd0);
        check("lit_postrst_addr", imem_addr, 32'h0);
        ack_force = 1'b0;

        // mixed pseudo-random traffic
        for (int i = 0; i < 80; i++) begin
            ack_en      = 1'($urandom_range(0, 1));
            inst_ready  = 1'($urandom_range(0, 1));
            redirect    = ($urandom_range(0, 9) == 0);
            redirect_pc = $urandom;
            halt        = ($urandom_range(0, 7) == 0);
            cycles(1);
        end
        redirect = 1'b0; halt = 1'b0;

        // address wrap instance
        rst_w = 1'b1;
        cycles(2);
        check("lit_wrap_pc0", pc_w, 32'hFFFFFFF8);
        check("lit_wrap_addr1", addr_w, 32'hFFFFFFFC);
        cycles(1);
        check("lit_wrap_addr2", addr_w, 32'h00000000);
        check("lit_wrap_count", {29'b0, count_w}, 32'd2);
        ready_w = 1'b1;
        cycles(1);
        check("lit_wrap_pc1", pc_w, 32'hFFFFFFFC);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
